mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the core's instruction-fetch and data-access requests onto one shared Wishbone-classic memory port, and generates the `mem_busy` stall that freezes every pipeline register while an access is outstanding. It sits between the pipelined dataflow (fetch address, load/store controls) and the system bus. Each pipeline step is serviced as follows: the data access (from the MEM stage) first, then the instruction fetch (from the IF stage), then one release cycle.

## Interface
- `DATA_SIZE`, 32: datapath and bus width. Legal values are 32 and 64.
- `TIMEOUT`, 255: maximum number of cycles to wait for `bus_ack` before an access is aborted. Range is 1 to 255.

Ports:
- `clock` in 1: the single clock; everything is on the rising edge.
- `reset` in 1: synchronous reset, active low, sampled on `clock`.
- `inst_req` in 1: IF stage requests a fetch.
- `inst_addr` in DATA_SIZE: fetch address.
- `inst_data` out 32: last fetched instruction.
- `data_rd_en` in 1: MEM stage load request.
- `data_wr_en` in 1: MEM stage store request.
- `data_addr` in DATA_SIZE: load/store address.
- `data_wr_data` in DATA_SIZE: store data.
- `data_byte_en` in DATA_SIZE/8: byte lanes for the data access.
- `data_rd_data` out DATA_SIZE: last load result.
- `mem_busy` out 1: stall the whole pipeline.
- `bus_timeout` out 1: one-cycle pulse when an access is aborted.
- `bus_cyc`, `bus_stb`, `bus_we` out 1: bus cycle, strobe and write enable.
- `bus_addr` out DATA_SIZE: bus address.
- `bus_sel` out DATA_SIZE/8: bus byte selects.
- `bus_wr_data` out DATA_SIZE: bus write data.
- `bus_rd_data` in DATA_SIZE: bus read data.
- `bus_ack` in 1: bus acknowledge.

## Operation
- The FSM has four states: `Idle`, `Data`, `Inst`, `Done`.
- A data request is present when `data_rd_en | data_wr_en`. If both are high, the access is a write.

Transitions:
- From `Idle`:
  - Data request present: go to `Data`.
  - Otherwise `inst_req`: go to `Inst`.
  - Otherwise stay in `Idle`.
- On leaving `Idle`, capture `data_addr`, `data_wr_data`, `data_byte_en`, the write flag, `inst_addr` and `inst_req` into internal registers. Later input changes are ignored until the next `Idle`.
- From `Data`:
  - On `bus_ack` (or timeout), go to `Inst` if the captured `inst_req` is set.
  - Otherwise go to `Done`.
- From `Inst`: on `bus_ack` (or timeout), go to `Done`.
- From `Done`: always go to `Idle` after exactly one cycle.

Bus outputs:
- In `Data`: `bus_cyc=bus_stb=1`, with `bus_we`, `bus_addr`, `bus_sel` and `bus_wr_data` taken from the captured data fields.
- In `Inst`: `bus_cyc=bus_stb=1`, `bus_we=0`, `bus_addr` from the captured fetch address, `bus_sel` all ones, `bus_wr_data=0`.
- In all other states every bus output is 0.

Result capture:
- Loads: on `bus_ack` in `Data` with the write flag clear, `data_rd_data <= bus_rd_data`. Stores leave `data_rd_data` unchanged.
- Fetches: on `bus_ack` in `Inst`, `inst_data` is loaded as follows.
  - DATA_SIZE=32: `bus_rd_data`.
  - DATA_SIZE=64: `bus_rd_data[63:32]` if the captured address bit 2 is set, else `bus_rd_data[31:0]`.
- Both result registers hold their value until they are next captured.

Timeout:
- A counter clears on entry to `Data`/`Inst` and increments every cycle while there is no `bus_ack`.
- When the count reaches `TIMEOUT`:
  - the access is abandoned;
  - the result register being written loads 0 (loads and fetches only);
  - `bus_timeout` pulses for 1 cycle;
  - the FSM advances exactly as it would on `bus_ack`.

`mem_busy` (combinational):
- Equals `(inst_req | data_rd_en | data_wr_en)` while in `Idle`.
- Is 1 in `Data` and `Inst`.
- Is 0 in `Done`.
- Is forced to 0 while `reset` is low.

## Timing
Reset behaviour:
- When `reset` is low at a clock edge, the state goes to `Idle`. The counter, `inst_data`, `data_rd_data`, `bus_timeout` and all bus outputs become 0.
- A reset in the middle of an access drops `bus_cyc` and `bus_stb` on the next edge. No result is captured.

Latency, with the bus acking in the first strobe cycle:
- Fetch only: 3 cycles (`Idle`, `Inst`, `Done`). `mem_busy` is high for 2 of them.
- Load or store plus fetch: 4 cycles.
- Each extra wait state adds 1 cycle.

Pipeline handshake:
- The pipeline advances on the edge that ends `Done`. That is the only edge in a request sequence where `mem_busy=0`.
- The results are valid in `Done`.
- The pipeline holds its request inputs stable while `mem_busy=1`. The arbiter does not rely on this, because it captured them on leaving `Idle`.

Other boundaries:
- `bus_ack` outside `Data`/`Inst` is ignored.
- `bus_ack` together with a timeout in the same cycle is treated as `bus_ack`: the data is captured and there is no `bus_timeout` pulse.
- With no requests present, the block stays in `Idle` with `mem_busy=0`.

## Test plan
- **Reset:** hold `reset=0` for 2 cycles with `inst_req=1` -> all outputs 0 and `mem_busy=0`. Then release -> `Inst` is entered one cycle later.
- **Fetch only:** DATA_SIZE=32, `inst_addr=0x100`, bus acks on its first strobe cycle with `0x00500093` -> `bus_addr=0x100`, `bus_sel=4'hF`, `inst_data=0x00500093` in `Done`, `mem_busy` high for exactly 2 cycles.
- **Load then fetch:** `data_rd_en=1`, `data_addr=0x2000`, `inst_addr=0x104`, 2 wait states on each access -> the data access is issued first, `data_rd_data` equals the bus value, total 8 cycles.
- **Store with byte lanes:** `data_wr_en=1`, `data_byte_en=4'b0011`, `data_wr_data=0xDEADBEEF` -> `bus_we=1`, `bus_sel=4'b0011`, `data_rd_data` unchanged.
- **Timeout:** `TIMEOUT=4`, bus never acks a fetch -> `bus_timeout` pulses on the 4th `Inst` cycle, `inst_data=0`, and the FSM reaches `Done`.
- **Reset mid-access and 64-bit fetch:** drop `reset` during `Data` -> `bus_cyc=0` on the next edge. Separately, with DATA_SIZE=64 and `inst_addr=0x104`, the upper word is selected into `inst_data`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the MEM-stage data access and the IF-stage
// fetch of one pipeline step onto a single Wishbone-classic port, and stalls
// the pipeline through mem_busy until both accesses have completed.
module mem_port_arbiter #(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   inst_req,
   input  logic [DATA_SIZE-1:0]   inst_addr,
   output logic [31:0]            inst_data,
   input  logic                   data_rd_en,
   input  logic                   data_wr_en,
   input  logic [DATA_SIZE-1:0]   data_addr,
   input  logic [DATA_SIZE-1:0]   data_wr_data,
   input  logic [DATA_SIZE/8-1:0] data_byte_en,
   output logic [DATA_SIZE-1:0]   data_rd_data,
   output logic                   mem_busy,
   output logic                   bus_timeout,
   output logic                   bus_cyc,
   output logic                   bus_stb,
   output logic                   bus_we,
   output logic [DATA_SIZE-1:0]   bus_addr,
   output logic [DATA_SIZE/8-1:0] bus_sel,
   output logic [DATA_SIZE-1:0]   bus_wr_data,
   input  logic [DATA_SIZE-1:0]   bus_rd_data,
   input  logic                   bus_ack
);

   localparam int unsigned SEL_W = DATA_SIZE / 8;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      INST = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state;
   logic                 cap_we;
   logic                 cap_inst_req;
   logic [DATA_SIZE-1:0] cap_inst_addr;
   logic [CNT_W-1:0]     wait_cnt;

   logic                 data_req_c;
   logic                 in_access_c;
   logic                 ack_c;
   logic                 expire_c;
   logic                 finish_c;
   logic [31:0]          fetch_word_c;

   // Request decode and access-termination conditions; an ack always wins
   // over a timeout expiring in the same cycle.
   assign data_req_c  = data_rd_en | data_wr_en;
   assign in_access_c = (state == DATA) || (state == INST);
   assign ack_c       = in_access_c & bus_ack;
   assign expire_c    = in_access_c & ~bus_ack & (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign finish_c    = ack_c | expire_c;

   // Instruction word selection: on a 64-bit bus address bit 2 picks the half.
   generate
      if (DATA_SIZE == 64) begin : g_wide_fetch
         assign fetch_word_c = cap_inst_addr[2] ? bus_rd_data[63:32] : bus_rd_data[31:0];
      end else begin : g_narrow_fetch
         assign fetch_word_c = bus_rd_data[31:0];
      end
   endgenerate

   // Sequencer: state, request capture, wait counter, results and the
   // registered bus interface. The data-access fields are held directly in the
   // bus output registers, loaded on the edge that leaves IDLE.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         cap_we        <= 1'b0;
         cap_inst_req  <= 1'b0;
         cap_inst_addr <= '0;
         wait_cnt      <= '0;
         inst_data     <= '0;
         data_rd_data  <= '0;
         bus_timeout   <= 1'b0;
         bus_cyc       <= 1'b0;
         bus_stb       <= 1'b0;
         bus_we        <= 1'b0;
         bus_addr      <= '0;
         bus_sel       <= '0;
         bus_wr_data   <= '0;
      end else begin
         bus_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (data_req_c || inst_req) begin
                  cap_we        <= data_wr_en;
                  cap_inst_req  <= inst_req;
                  cap_inst_addr <= inst_addr;
                  wait_cnt      <= '0;
               end
               if (data_req_c) begin
                  state       <= DATA;
                  bus_cyc     <= 1'b1;
                  bus_stb     <= 1'b1;
                  bus_we      <= data_wr_en;
                  bus_addr    <= data_addr;
                  bus_sel     <= data_byte_en;
                  bus_wr_data <= data_wr_data;
               end else if (inst_req) begin
                  state       <= INST;
                  bus_cyc     <= 1'b1;
                  bus_stb     <= 1'b1;
                  bus_we      <= 1'b0;
                  bus_addr    <= inst_addr;
                  bus_sel     <= {SEL_W{1'b1}};
                  bus_wr_data <= '0;
               end
            end

            DATA: begin
               if (finish_c) begin
                  if (!cap_we) begin
                     data_rd_data <= ack_c ? bus_rd_data : '0;
                  end
                  bus_timeout <= expire_c;
                  wait_cnt    <= '0;
                  if (cap_inst_req) begin
                     state       <= INST;
                     bus_cyc     <= 1'b1;
                     bus_stb     <= 1'b1;
                     bus_we      <= 1'b0;
                     bus_addr    <= cap_inst_addr;
                     bus_sel     <= {SEL_W{1'b1}};
                     bus_wr_data <= '0;
                  end else begin
                     state       <= DONE;
                     bus_cyc     <= 1'b0;
                     bus_stb     <= 1'b0;
                     bus_we      <= 1'b0;
                     bus_addr    <= '0;
                     bus_sel     <= '0;
                     bus_wr_data <= '0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            INST: begin
               if (finish_c) begin
                  inst_data   <= ack_c ? fetch_word_c : 32'h0;
                  bus_timeout <= expire_c;
                  wait_cnt    <= '0;
                  state       <= DONE;
                  bus_cyc     <= 1'b0;
                  bus_stb     <= 1'b0;
                  bus_we      <= 1'b0;
                  bus_addr    <= '0;
                  bus_sel     <= '0;
                  bus_wr_data <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Pipeline stall: live request decode in IDLE, held through the accesses,
   // released in DONE so the pipeline advances on the edge that ends it.
   always_comb begin
      mem_busy = 1'b0;
      if (reset) begin
         case (state)
            IDLE:    mem_busy = data_req_c | inst_req;
            DATA:    mem_busy = 1'b1;
            INST:    mem_busy = 1'b1;
            default: mem_busy = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 32-bit instance (TIMEOUT=4) exercised by a
// vector table, hand sequences and random transactions scored against a
// transaction-level model, plus a 64-bit instance for wide fetch/load.
module tb_mem_port_arbiter;

   localparam int TO = 4;

   logic        clock;
   logic        reset;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic        data_rd_en;
   logic        data_wr_en;
   logic [31:0] data_addr;
   logic [31:0] data_wr_data;
   logic [3:0]  data_byte_en;
   logic [31:0] data_rd_data;
   logic        mem_busy;
   logic        bus_timeout;
   logic        bus_cyc;
   logic        bus_stb;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wr_data;
   logic [31:0] bus_rd_data;
   logic        bus_ack;

   logic        w_inst_req;
   logic [63:0] w_inst_addr;
   logic [31:0] w_inst_data;
   logic        w_data_rd_en;
   logic        w_data_wr_en;
   logic [63:0] w_data_addr;
   logic [63:0] w_data_wr_data;
   logic [7:0]  w_data_byte_en;
   logic [63:0] w_data_rd_data;
   logic        w_mem_busy;
   logic        w_bus_timeout;
   logic        w_bus_cyc;
   logic        w_bus_stb;
   logic        w_bus_we;
   logic [63:0] w_bus_addr;
   logic [7:0]  w_bus_sel;
   logic [63:0] w_bus_wr_data;
   logic [63:0] w_bus_rd_data;
   logic        w_bus_ack;

   mem_port_arbiter #(.DATA_SIZE(32), .TIMEOUT(TO)) dut32 (
      .clock(clock), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_data(inst_data),
      .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_addr(data_addr),
      .data_wr_data(data_wr_data), .data_byte_en(data_byte_en), .data_rd_data(data_rd_data),
      .mem_busy(mem_busy), .bus_timeout(bus_timeout),
      .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_sel(bus_sel), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_ack(bus_ack)
   );

   mem_port_arbiter #(.DATA_SIZE(64), .TIMEOUT(TO)) dut64 (
      .clock(clock), .reset(reset),
      .inst_req(w_inst_req), .inst_addr(w_inst_addr), .inst_data(w_inst_data),
      .data_rd_en(w_data_rd_en), .data_wr_en(w_data_wr_en), .data_addr(w_data_addr),
      .data_wr_data(w_data_wr_data), .data_byte_en(w_data_byte_en), .data_rd_data(w_data_rd_data),
      .mem_busy(w_mem_busy), .bus_timeout(w_bus_timeout),
      .bus_cyc(w_bus_cyc), .bus_stb(w_bus_stb), .bus_we(w_bus_we), .bus_addr(w_bus_addr),
      .bus_sel(w_bus_sel), .bus_wr_data(w_bus_wr_data), .bus_rd_data(w_bus_rd_data), .bus_ack(w_bus_ack)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic        iq;
      logic [31:0] da;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] ia;
      int          ws_d;
      int          ws_i;
      logic [31:0] rd_d;
      logic [31:0] rd_i;
   } txn_t;

   typedef struct {
      txn_t        t;
      logic [31:0] e_inst;
      logic [31:0] e_drd;
      int          e_busy;
   } vec_t;

   localparam int NV = 8;
   vec_t vec[NV];

   int          n_checks;
   int          n_fail;
   logic [31:0] m_inst;
   logic [31:0] m_drd;
   logic [31:0] w_m_inst;
   logic [63:0] w_m_drd;

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no completion, expected summary");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic rd, input logic wr, input logic iq,
                                input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
                                input logic [31:0] ia, input int ws_d, input int ws_i,
                                input logic [31:0] rd_d, input logic [31:0] rd_i,
                                input logic [31:0] e_inst, input logic [31:0] e_drd, input int e_busy);
      vec_t v;
      v.t.rd = rd; v.t.wr = wr; v.t.iq = iq; v.t.da = da; v.t.wd = wd; v.t.be = be;
      v.t.ia = ia; v.t.ws_d = ws_d; v.t.ws_i = ws_i; v.t.rd_d = rd_d; v.t.rd_i = rd_i;
      v.e_inst = e_inst; v.e_drd = e_drd; v.e_busy = e_busy;
      return v;
   endfunction

   // Request inputs are meaningless once captured; churn them to prove it.
   task automatic scramble();
      inst_req     = 1'($urandom);
      data_rd_en   = 1'($urandom);
      data_wr_en   = 1'($urandom);
      inst_addr    = $urandom;
      data_addr    = $urandom;
      data_wr_data = $urandom;
      data_byte_en = 4'($urandom);
   endtask

   // One pipeline step on dut32, called and returning at a negedge in IDLE.
   // The bus responder follows the schedule the model expects; any deviation
   // in the DUT shows up as a bus or stall mismatch.
   task automatic run_txn(input txn_t t, output int busy);
      logic        a_we[2];
      logic [31:0] a_addr[2];
      logic [31:0] a_wd[2];
      logic [31:0] a_rdv[2];
      logic [3:0]  a_sel[2];
      int          a_ws[2];
      int          n = 0;
      int          len;
      int          exp_busy;
      logic        prev_to = 1'b0;
      logic        req;
      busy = 0;
      req  = t.rd | t.wr | t.iq;
      if (t.rd | t.wr) begin
         a_we[n] = t.wr; a_addr[n] = t.da; a_wd[n] = t.wd; a_sel[n] = t.be;
         a_ws[n] = t.ws_d; a_rdv[n] = t.rd_d; n++;
      end
      if (t.iq) begin
         a_we[n] = 1'b0; a_addr[n] = t.ia; a_wd[n] = 32'h0; a_sel[n] = 4'hF;
         a_ws[n] = t.ws_i; a_rdv[n] = t.rd_i; n++;
      end
      exp_busy = req ? 1 : 0;
      for (int j = 0; j < n; j++) exp_busy += (a_ws[j] < TO) ? a_ws[j] + 1 : TO;

      // idle slot
      check("idle_cyc", 64'(bus_cyc), 64'(0));
      check("idle_timeout", 64'(bus_timeout), 64'(0));
      check("idle_inst_data", 64'(inst_data), 64'(m_inst));
      check("idle_data_rd_data", 64'(data_rd_data), 64'(m_drd));
      data_rd_en = t.rd; data_wr_en = t.wr; inst_req = t.iq;
      data_addr = t.da; data_wr_data = t.wd; data_byte_en = t.be; inst_addr = t.ia;
      bus_ack = 1'($urandom); bus_rd_data = $urandom;
      #1;
      check("idle_busy", 64'(mem_busy), 64'(req));
      if (mem_busy) busy++;

      if ((t.rd | t.wr) && !t.wr) m_drd = (t.ws_d < TO) ? t.rd_d : 32'h0;
      if (t.iq) m_inst = (t.ws_i < TO) ? t.rd_i : 32'h0;

      for (int j = 0; j < n; j++) begin
         len = (a_ws[j] < TO) ? a_ws[j] + 1 : TO;
         for (int k = 0; k < len; k++) begin
            @(negedge clock);
            check("acc_cyc", 64'(bus_cyc), 64'(1));
            check("acc_stb", 64'(bus_stb), 64'(1));
            check("acc_we", 64'(bus_we), 64'(a_we[j]));
            check("acc_addr", 64'(bus_addr), 64'(a_addr[j]));
            check("acc_sel", 64'(bus_sel), 64'(a_sel[j]));
            check("acc_wr_data", 64'(bus_wr_data), 64'(a_wd[j]));
            check("acc_timeout", 64'(bus_timeout), 64'((k == 0) && prev_to));
            scramble();
            bus_ack     = (k == a_ws[j]);
            bus_rd_data = (k == a_ws[j]) ? a_rdv[j] : $urandom;
            #1;
            check("acc_busy", 64'(mem_busy), 64'(1));
            if (mem_busy) busy++;
         end
         prev_to = (a_ws[j] >= TO);
      end

      if (n > 0) begin
         @(negedge clock);
         check("done_cyc", 64'(bus_cyc), 64'(0));
         check("done_stb", 64'(bus_stb), 64'(0));
         check("done_we", 64'(bus_we), 64'(0));
         check("done_addr", 64'(bus_addr), 64'(0));
         check("done_sel", 64'(bus_sel), 64'(0));
         check("done_wr_data", 64'(bus_wr_data), 64'(0));
         check("done_timeout", 64'(bus_timeout), 64'(prev_to));
         check("done_inst_data", 64'(inst_data), 64'(m_inst));
         check("done_data_rd_data", 64'(data_rd_data), 64'(m_drd));
         scramble();
         bus_ack = 1'($urandom); bus_rd_data = $urandom;
         #1;
         check("done_busy", 64'(mem_busy), 64'(0));
      end
      check("busy_cycles", 64'(busy), 64'(exp_busy));
      @(negedge clock);
   endtask

   // Wide-port step on dut64: optional load, then fetch, zero wait states.
   task automatic txn64(input logic rd, input logic [63:0] da, input logic [7:0] be,
                        input logic [63:0] ia, input logic [63:0] rdd, input logic [63:0] rdi);
      w_data_rd_en = rd; w_data_wr_en = 1'b0; w_data_addr = da; w_data_byte_en = be;
      w_data_wr_data = 64'h0; w_inst_req = 1'b1; w_inst_addr = ia; w_bus_ack = 1'b0;
      #1;
      check("w_idle_busy", 64'(w_mem_busy), 64'(1));
      if (rd) begin
         @(negedge clock);
         check("w_data_cyc", 64'(w_bus_cyc), 64'(1));
         check("w_data_addr", w_bus_addr, da);
         check("w_data_sel", 64'(w_bus_sel), 64'(be));
         check("w_data_we", 64'(w_bus_we), 64'(0));
         w_bus_ack = 1'b1; w_bus_rd_data = rdd; w_m_drd = rdd;
      end
      @(negedge clock);
      check("w_inst_cyc", 64'(w_bus_cyc), 64'(1));
      check("w_inst_addr", w_bus_addr, ia);
      check("w_inst_sel", 64'(w_bus_sel), 64'(8'hFF));
      w_bus_ack = 1'b1; w_bus_rd_data = rdi;
      w_m_inst = ia[2] ? rdi[63:32] : rdi[31:0];
      @(negedge clock);
      w_bus_ack = 1'b0; w_inst_req = 1'b0; w_data_rd_en = 1'b0;
      check("w_done_cyc", 64'(w_bus_cyc), 64'(0));
      check("w_inst_data", 64'(w_inst_data), 64'(w_m_inst));
      check("w_data_rd_data", w_data_rd_data, w_m_drd);
      #1;
      check("w_done_busy", 64'(w_mem_busy), 64'(0));
      @(negedge clock);
   endtask

   initial begin
      txn_t t;
      int   busy;

      vec[0] = mkv(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h100, 0, 0,
                   32'h0, 32'h00500093, 32'h00500093, 32'h0, 2);
      vec[1] = mkv(1'b1, 1'b0, 1'b1, 32'h2000, 32'h0, 4'hF, 32'h104, 2, 2,
                   32'hCAFEF00D, 32'h00A00113, 32'h00A00113, 32'hCAFEF00D, 7);
      vec[2] = mkv(1'b0, 1'b1, 1'b1, 32'h3000, 32'hDEADBEEF, 4'b0011, 32'h108, 0, 0,
                   32'h11111111, 32'h00000013, 32'h00000013, 32'hCAFEF00D, 3);
      vec[3] = mkv(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10C, 0, 9,
                   32'h0, 32'h99999999, 32'h0, 32'hCAFEF00D, 5);
      vec[4] = mkv(1'b1, 1'b1, 1'b0, 32'h4000, 32'h55AA55AA, 4'hF, 32'h0, 1, 0,
                   32'h22222222, 32'h0, 32'h0, 32'hCAFEF00D, 3);
      vec[5] = mkv(1'b1, 1'b0, 1'b1, 32'h5000, 32'h0, 4'hF, 32'h110, 7, 3,
                   32'h77777777, 32'h12345678, 32'h12345678, 32'h0, 9);
      vec[6] = mkv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0,
                   32'h0, 32'h0, 32'h12345678, 32'h0, 0);
      vec[7] = mkv(1'b1, 1'b0, 1'b0, 32'h6000, 32'h0, 4'hC, 32'h0, 3, 0,
                   32'h0BADF00D, 32'h0, 32'h12345678, 32'h0BADF00D, 5);

      n_checks = 0; n_fail = 0;
      m_inst = 32'h0; m_drd = 32'h0; w_m_inst = 32'h0; w_m_drd = 64'h0;
      clock = 1'b0; reset = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h0; data_rd_en = 1'b0; data_wr_en = 1'b0;
      data_addr = 32'h0; data_wr_data = 32'h0; data_byte_en = 4'h0;
      bus_rd_data = 32'h0; bus_ack = 1'b0;
      w_inst_req = 1'b0; w_inst_addr = 64'h0; w_data_rd_en = 1'b0; w_data_wr_en = 1'b0;
      w_data_addr = 64'h0; w_data_wr_data = 64'h0; w_data_byte_en = 8'h0;
      w_bus_rd_data = 64'h0; w_bus_ack = 1'b0;

      // reset held with a pending fetch
      repeat (2) begin
         @(negedge clock);
         check("rst_busy", 64'(mem_busy), 64'(0));
         check("rst_cyc", 64'(bus_cyc), 64'(0));
         check("rst_stb", 64'(bus_stb), 64'(0));
         check("rst_addr", 64'(bus_addr), 64'(0));
         check("rst_timeout", 64'(bus_timeout), 64'(0));
         check("rst_inst_data", 64'(inst_data), 64'(0));
         check("rst_data_rd_data", 64'(data_rd_data), 64'(0));
         check("rst_w_cyc", 64'(w_bus_cyc), 64'(0));
         check("rst_w_data_rd_data", w_data_rd_data, 64'h0);
      end
      reset = 1'b1;
      t = mkv(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0,
              32'h0, 32'hABCD0001, 32'h0, 32'h0, 0).t;
      run_txn(t, busy);

      for (int i = 0; i < NV; i++) begin
         run_txn(vec[i].t, busy);
         check("vec_busy", 64'(busy), 64'(vec[i].e_busy));
         check("vec_inst_data", 64'(inst_data), 64'(vec[i].e_inst));
         check("vec_data_rd_data", 64'(data_rd_data), 64'(vec[i].e_drd));
      end

      // reset dropped while a load is on the bus
      data_rd_en = 1'b1; data_wr_en = 1'b0; inst_req = 1'b1;
      data_addr = 32'h7000; inst_addr = 32'h200; bus_ack = 1'b0;
      @(negedge clock);
      check("mid_data_cyc", 64'(bus_cyc), 64'(1));
      check("mid_data_addr", 64'(bus_addr), 64'(32'h7000));
      reset = 1'b0; bus_ack = 1'b1; bus_rd_data = 32'hFEEDFACE;
      #1;
      check("mid_rst_busy", 64'(mem_busy), 64'(0));
      @(negedge clock);
      check("mid_rst_cyc", 64'(bus_cyc), 64'(0));
      check("mid_rst_stb", 64'(bus_stb), 64'(0));
      check("mid_rst_data_rd_data", 64'(data_rd_data), 64'(0));
      check("mid_rst_inst_data", 64'(inst_data), 64'(0));
      m_drd = 32'h0; m_inst = 32'h0;
      data_rd_en = 1'b0; inst_req = 1'b0; bus_ack = 1'b0; reset = 1'b1;
      @(negedge clock);
      check("post_rst_cyc", 64'(bus_cyc), 64'(0));

      // random steps against the transaction model
      for (int i = 0; i < 300; i++) begin
         t.rd   = 1'($urandom);
         t.wr   = 1'($urandom);
         t.iq   = 1'($urandom);
         t.da   = $urandom;
         t.wd   = $urandom;
         t.be   = 4'($urandom);
         t.ia   = $urandom;
         t.ws_d = int'($urandom_range(0, 5));
         t.ws_i = int'($urandom_range(0, 5));
         t.rd_d = $urandom;
         t.rd_i = $urandom;
         run_txn(t, busy);
      end

      // 64-bit port: word selection by address bit 2, and a wide load
      txn64(1'b0, 64'h0, 8'h0, 64'h104, 64'h0, 64'h11112222_33334444);
      check("w_upper_word", 64'(w_inst_data), 64'(32'h11112222));
      txn64(1'b0, 64'h0, 8'h0, 64'h100, 64'h0, 64'h55556666_77778888);
      check("w_lower_word", 64'(w_inst_data), 64'(32'h77778888));
      txn64(1'b1, 64'h8000, 8'hF0, 64'h10C, 64'h0123456789ABCDEF, 64'hAAAABBBB_CCCCDDDD);
      check("w_load_value", w_data_rd_data, 64'h0123456789ABCDEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
